// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes and variable-latency data-memory waits with timeout.
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             branch_taken,
   input  logic             mem_access,
   input  logic             mem_ack,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic             mem_req,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic load_use;
   logic timed_out;
   logic mem_stall;

   // Hazard detection; a wait that hits TIMEOUT without an ack releases like an ack.
   always_comb begin
      load_use  = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
      timed_out = (state_q == MEM_WAIT) && !mem_ack && (wait_q >= TIMEOUT_L);
      if (state_q == RUN) begin
         mem_stall = mem_access && !mem_ack;
      end else begin
         mem_stall = !mem_ack && !timed_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= 8'd0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d = MEM_WAIT;
               wait_d  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_stall) begin
               wait_d = wait_q + 8'd1;
            end else begin
               state_d = RUN;
               wait_d  = 8'd0;
               if (timed_out) begin
                  err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = RUN;
            wait_d  = 8'd0;
         end
      endcase
      // Branch flush cycles are not stalls; the counter saturates at all-ones.
      if ((mem_stall || (!branch_taken && load_use)) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b0;
      mem_req       = 1'b0;
      if (!rst) begin
         mem_req = mem_access || (state_q == MEM_WAIT);
         if (mem_stall) begin
            mem_wb_bubble = 1'b1;
         end else begin
            ex_mem_write = 1'b1;
            if (branch_taken) begin
               pc_write    = 1'b1;
               if_id_write = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               id_ex_flush = 1'b1;
            end else begin
               pc_write    = 1'b1;
               if_id_write = 1'b1;
            end
         end
      end
   end

   assign mem_error   = err_q;
   assign stall_count = cnt_q;

endmodule
